grid_feeder: RTL and testbench

Upstream sequencer for grid_1. It accepts signed 8-bit input samples, each paired with a weight sign bit, over a valid/ready stream and buffers them in a small FIFO. It presents one sample at a time on din/sign, fires a single-cycle trig, and holds the sample stable for a fixed DTC conversion window. It counts samples per frame and pulses frame_done after the last conversion of each frame.

---
 rtl/grid_feeder.sv | 183 ++++++++++++++++++
 tb/tb_grid_feeder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_feeder.sv
// ============================================================================
// Module   : grid_feeder
// Purpose  : Upstream sequencer for grid_1. Accepts signed samples paired with
//            a weight sign bit over a valid/ready stream, buffers them in a
//            small circular FIFO, and issues them one at a time to grid_1.
//            Each issue is a one-cycle trig, after which din/sign are held for
//            a fixed DTC conversion window. Samples are counted per frame, and
//            frame_done pulses after the last conversion of each frame.
// Ports    : clk        - system clock, rising edge
//            rst        - asynchronous active-low reset
//            clr        - synchronous soft clear (flush FIFO, abort, idx=0)
//            s_data     - incoming sample (two's complement)
//            s_sign     - weight sign for the incoming sample
//            s_valid    - s_data/s_sign valid
//            s_ready    - FIFO can accept a sample
//            din        - sample presented to grid_1
//            sign       - weight sign presented to grid_1
//            trig       - one-cycle conversion start pulse
//            busy       - high while in TRIG or CONV
//            sample_idx - index of the current/last issued sample in the frame
//            frame_done - one-cycle pulse at the end of the Nth conversion
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module grid_feeder #(
  parameter int DW          = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int CONV_CYCLES = 260,
  parameter int N_INPUTS    = 8
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             clr,
  input  logic [DW-1:0]                                    s_data,
  input  logic                                             s_sign,
  input  logic                                             s_valid,
  output logic                                             s_ready,
  output logic [DW-1:0]                                    din,
  output logic                                             sign,
  output logic                                             trig,
  output logic                                             busy,
  output logic [((N_INPUTS > 1) ? $clog2(N_INPUTS) : 1)-1:0] sample_idx,
  output logic                                             frame_done
);

  localparam int c_AW = $clog2(FIFO_DEPTH);
  localparam int c_CW = $clog2(CONV_CYCLES);
  localparam int c_IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  localparam logic [c_AW:0]   c_FULL_CNT = (c_AW + 1)'(FIFO_DEPTH);
  localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(CONV_CYCLES - 1);
  localparam logic [c_IW-1:0] c_IDX_LAST = c_IW'(N_INPUTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TRIG = 2'd1,
    CONV = 2'd2
  } state_t;

  // FIFO storage: {sign, data} per entry
  logic [DW:0]     mem_q [FIFO_DEPTH];
  logic [c_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_AW:0]   count_q,  count_d;

  state_t          state_q;
  logic [DW-1:0]   din_q;
  logic            sign_q;
  logic            trig_q;
  logic            frame_done_q;
  logic [c_IW-1:0] idx_q;
  logic [c_CW-1:0] cnt_q;

  logic            push;
  logic            pop;
  logic [DW:0]     head;

  // s_ready comes straight from the registered count, so it never depends
  // combinationally on s_valid.
  assign s_ready = (count_q != c_FULL_CNT);

  // clr drops a same-cycle push and blocks a same-cycle pop.
  assign push = s_valid && s_ready && !clr;
  assign pop  = (state_q == IDLE) && (count_q != '0) && !clr;
  assign head = mem_q[rd_ptr_q];

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + c_AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + c_AW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + (c_AW + 1)'(1);
      2'b01:   count_d = count_q - (c_AW + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {s_sign, s_data};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      din_q        <= '0;
      sign_q       <= 1'b0;
      trig_q       <= 1'b0;
      frame_done_q <= 1'b0;
      idx_q        <= '0;
      cnt_q        <= '0;
    end else if (clr) begin
      // Same as reset except din/sign keep the last presented sample.
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      state_q      <= IDLE;
      trig_q       <= 1'b0;
      frame_done_q <= 1'b0;
      idx_q        <= '0;
      cnt_q        <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            din_q   <= head[DW-1:0];
            sign_q  <= head[DW];
            trig_q  <= 1'b1;
            state_q <= TRIG;
          end
        end
        TRIG: begin
          trig_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= CONV;
        end
        CONV: begin
          if (cnt_q == c_CNT_LAST) begin
            state_q <= IDLE;
            if (idx_q == c_IDX_LAST) begin
              frame_done_q <= 1'b1;
              idx_q        <= '0;
            end else begin
              idx_q <= idx_q + c_IW'(1);
            end
          end else begin
            cnt_q <= cnt_q + c_CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign din        = din_q;
  assign sign       = sign_q;
  assign trig       = trig_q;
  assign busy       = (state_q != IDLE);
  assign sample_idx = idx_q;
  assign frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_grid_feeder.sv
// ============================================================================
// Module   : tb_grid_feeder
// Purpose  : Directed self-checking bench for grid_feeder with
//            CONV_CYCLES=16, N_INPUTS=4, FIFO_DEPTH=4, DW=8.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_grid_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_sign = 1'b0;
  logic       s_valid = 1'b0;
  logic       s_ready;
  logic [7:0] din;
  logic       sign;
  logic       trig;
  logic       busy;
  logic [1:0] sample_idx;
  logic       frame_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  grid_feeder #(
    .DW(8), .FIFO_DEPTH(4), .CONV_CYCLES(16), .N_INPUTS(4)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .s_data(s_data), .s_sign(s_sign), .s_valid(s_valid), .s_ready(s_ready),
    .din(din), .sign(sign), .trig(trig), .busy(busy),
    .sample_idx(sample_idx), .frame_done(frame_done)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    s_valid = 1'b0;
    clr = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({din, sign, trig, busy, frame_done, sample_idx, s_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_outputs actual din=%h sign=%b trig=%b busy=%b fd=%b idx=%0d rdy=%b required 00/0/0/0/0/0/1",
               din, sign, trig, busy, frame_done, sample_idx, s_ready);
    end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_single();
    int nb, nt;
    bit stable;
    apply_reset();
    s_data = 8'h85; s_sign = 1'b1; s_valid = 1'b1;
    tick();
    s_valid = 1'b0; s_data = 8'h00; s_sign = 1'b0;
    checks++;
    if (trig !== 1'b0) begin failures++; $display("FAIL single_trig_early actual=%b required=0", trig); end
    tick();
    checks++;
    if ({din, sign, trig, busy} !== {8'h85, 1'b1, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL single_issue actual din=%h sign=%b trig=%b busy=%b required 85/1/1/1", din, sign, trig, busy);
    end
    nb = 1; nt = 1; stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!busy) break;
      nb++;
      if (trig) nt++;
      if (din !== 8'h85 || sign !== 1'b1) stable = 1'b0;
    end
    checks++;
    if (nb != 17) begin failures++; $display("FAIL single_busy_len actual=%0d required=17", nb); end
    checks++;
    if (nt != 1) begin failures++; $display("FAIL single_trig_len actual=%0d required=1", nt); end
    checks++;
    if (!stable) begin failures++; $display("FAIL single_din_hold actual=unstable required=stable"); end
    checks++;
    if (sample_idx !== 2'd1) begin failures++; $display("FAIL single_idx actual=%0d required=1", sample_idx); end
  endtask

  task automatic test_back_to_back();
    int trig_t[$];
    logic [7:0] trig_d[$];
    int fd_t[$];
    int exp_t[4];
    exp_t = '{1, 19, 37, 55};
    apply_reset();
    for (int t = 0; t < 80; t++) begin
      if (t < 4) begin s_valid = 1'b1; s_data = 8'(t + 1); s_sign = 1'b0; end
      else s_valid = 1'b0;
      tick();
      if (trig === 1'b1) begin trig_t.push_back(t); trig_d.push_back(din); end
      if (frame_done === 1'b1) fd_t.push_back(t);
    end
    checks++;
    if (trig_t.size() != 4) begin
      failures++; $display("FAIL b2b_trig_count actual=%0d required=4", trig_t.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (trig_t[k] != exp_t[k] || trig_d[k] !== 8'(k + 1)) begin
          failures++;
          $display("FAIL b2b_trig%0d actual t=%0d din=%h required t=%0d din=%h", k, trig_t[k], trig_d[k], exp_t[k], 8'(k + 1));
        end
      end
    end
    // frame_done follows the 4th trig cycle plus 16 CONV cycles
    checks++;
    if (fd_t.size() != 1 || fd_t[0] != 72) begin
      failures++;
      $display("FAIL b2b_frame_done actual count=%0d first=%0d required count=1 t=72", fd_t.size(), (fd_t.size() > 0) ? fd_t[0] : -1);
    end
    checks++;
    if (sample_idx !== 2'd0) begin failures++; $display("FAIL b2b_idx_wrap actual=%0d required=0", sample_idx); end
  endtask

  task automatic test_backpressure();
    logic [7:0] sb[$];
    logic [7:0] nxt, expv;
    int accepts, pops, errs, low_acc, low_pops;
    bit was_ready, rdy_at_pop2, rdy_after_pop2, want_after;
    apply_reset();
    nxt = 8'h10; accepts = 0; pops = 0; errs = 0; low_acc = -1; low_pops = -1;
    rdy_at_pop2 = 1'b0; rdy_after_pop2 = 1'b1; want_after = 1'b0;
    s_valid = 1'b1;
    for (int t = 0; t < 120; t++) begin
      s_data = nxt; s_sign = nxt[0];
      was_ready = s_ready;
      tick();
      if (want_after) begin rdy_after_pop2 = s_ready; want_after = 1'b0; end
      if (trig) begin
        pops++;
        if (sb.size() == 0) errs++;
        else begin
          expv = sb.pop_front();
          if (din !== expv || sign !== expv[0]) errs++;
        end
        if (pops == 2) begin rdy_at_pop2 = s_ready; want_after = 1'b1; end
      end
      if (was_ready) begin sb.push_back(nxt); accepts++; nxt++; end
      if (low_acc < 0 && !s_ready) begin low_acc = accepts; low_pops = pops; end
    end
    s_valid = 1'b0;
    for (int i = 0; i < 400 && (sb.size() > 0 || busy); i++) begin
      tick();
      if (trig) begin
        pops++;
        if (sb.size() == 0) errs++;
        else begin
          expv = sb.pop_front();
          if (din !== expv || sign !== expv[0]) errs++;
        end
      end
    end
    for (int i = 0; i < 25; i++) begin
      tick();
      if (trig) begin pops++; errs++; end
    end
    checks++;
    if (low_acc != 5 || low_pops != 1) begin
      failures++; $display("FAIL bp_ready_drop actual acc=%0d pops=%0d required acc=5 pops=1", low_acc, low_pops);
    end
    checks++;
    if (rdy_at_pop2 !== 1'b1 || rdy_after_pop2 !== 1'b0) begin
      failures++; $display("FAIL bp_ready_rise actual at=%b after=%b required at=1 after=0", rdy_at_pop2, rdy_after_pop2);
    end
    checks++;
    if (errs != 0 || sb.size() != 0 || pops != accepts) begin
      failures++; $display("FAIL bp_scoreboard actual errs=%0d left=%0d pops=%0d acc=%0d required errs=0 left=0 pops=acc",
                           errs, sb.size(), pops, accepts);
    end
  endtask

  task automatic test_push_pop_same();
    logic [7:0] got[$];
    bit idle_seen;
    apply_reset();
    s_valid = 1'b1;
    s_data = 8'hA1; tick();
    s_data = 8'hA2; tick();
    s_data = 8'hA3; tick();
    s_valid = 1'b0;
    idle_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!busy) begin idle_seen = 1'b1; break; end
    end
    checks++;
    if (!idle_seen) begin failures++; $display("FAIL pp_idle_timeout actual=busy required=idle"); end
    // FIFO holds A2,A3: this edge pops A2 and pushes A4
    s_valid = 1'b1; s_data = 8'hA4; tick();
    checks++;
    if ({trig, din, s_ready} !== {1'b1, 8'hA2, 1'b1}) begin
      failures++; $display("FAIL pp_pop actual trig=%b din=%h rdy=%b required 1/a2/1", trig, din, s_ready);
    end
    s_data = 8'hA5; tick();
    checks++;
    if (s_ready !== 1'b1) begin failures++; $display("FAIL pp_count3 actual rdy=%b required=1", s_ready); end
    s_data = 8'hA6; tick();
    checks++;
    if (s_ready !== 1'b0) begin failures++; $display("FAIL pp_count4 actual rdy=%b required=0", s_ready); end
    s_valid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (trig) got.push_back(din);
    end
    checks++;
    if (got.size() != 4 || got[0] !== 8'hA3 || got[1] !== 8'hA4 || got[2] !== 8'hA5 || got[3] !== 8'hA6) begin
      failures++;
      $display("FAIL pp_order actual n=%0d %h %h %h %h required n=4 a3 a4 a5 a6", got.size(),
               (got.size() > 0) ? got[0] : 8'h00, (got.size() > 1) ? got[1] : 8'h00,
               (got.size() > 2) ? got[2] : 8'h00, (got.size() > 3) ? got[3] : 8'h00);
    end
  endtask

  task automatic test_async_reset();
    int ntrig;
    apply_reset();
    s_valid = 1'b1; s_data = 8'h3C; tick();
    s_valid = 1'b0; tick();
    for (int i = 0; i < 40; i++) begin tick(); if (!busy) break; end
    checks++;
    if (sample_idx !== 2'd1) begin failures++; $display("FAIL ar_pre_idx actual=%0d required=1", sample_idx); end
    s_valid = 1'b1; s_data = 8'h5A; s_sign = 1'b1; tick();
    s_data = 8'h66; tick();
    s_valid = 1'b0; s_sign = 1'b0;
    checks++;
    if ({trig, din} !== {1'b1, 8'h5A}) begin
      failures++; $display("FAIL ar_issue actual trig=%b din=%h required 1/5a", trig, din);
    end
    tick();                                   // CONV, counter=0
    for (int i = 0; i < 7; i++) tick();       // counter=7
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({din, sign, trig, busy, frame_done, sample_idx, s_ready} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1}) begin
      failures++;
      $display("FAIL ar_async actual din=%h sign=%b trig=%b busy=%b fd=%b idx=%0d rdy=%b required 00/0/0/0/0/0/1",
               din, sign, trig, busy, frame_done, sample_idx, s_ready);
    end
    tick();
    rst = 1'b1;
    ntrig = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (trig) ntrig++; end
    checks++;
    if (ntrig != 0) begin failures++; $display("FAIL ar_fifo_flushed actual trigs=%0d required=0", ntrig); end
    s_valid = 1'b1; s_data = 8'h11; tick();
    s_valid = 1'b0; tick();
    checks++;
    if ({trig, din, sample_idx} !== {1'b1, 8'h11, 2'd0}) begin
      failures++; $display("FAIL ar_fresh actual trig=%b din=%h idx=%0d required 1/11/0", trig, din, sample_idx);
    end
  endtask

  task automatic test_clr();
    int ntrig, bad;
    apply_reset();
    ntrig = 0;
    for (int t = 0; t < 100; t++) begin
      if (t < 5) begin s_valid = 1'b1; s_data = 8'(t + 1); end
      else s_valid = 1'b0;
      tick();
      if (trig) ntrig++;
      if (ntrig == 4) break;
    end
    s_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    clr = 1'b1; s_valid = 1'b1; s_data = 8'h77;
    tick();
    clr = 1'b0; s_valid = 1'b0;
    checks++;
    if ({busy, trig, frame_done, sample_idx, din, s_ready} !== {1'b0, 1'b0, 1'b0, 2'd0, 8'h04, 1'b1}) begin
      failures++;
      $display("FAIL clr_state actual busy=%b trig=%b fd=%b idx=%0d din=%h rdy=%b required 0/0/0/0/04/1",
               busy, trig, frame_done, sample_idx, din, s_ready);
    end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (trig || frame_done) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL clr_quiet actual events=%0d required=0", bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_push_pop_same();
    test_async_reset();
    test_clr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
